uart_tx_arbiter: RTL and testbench

Shares the single USB-UART transmitter (byte-level uart_tx: data/new_data/busy) between NUM_REQ on-chip byte sources, e.g. a status reporter, an rx echo path and an LED-state dumper.
- Grants are round-robin, held per message (until req_last) or for at most MAX_BURST bytes, whichever comes first.
- Sits between the requesters and uart_tx, whose tx output drives usb_tx.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter and related schedulers.
package uart_arb_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ISSUE,
    HOLDOFF
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus and uart_tx byte interface seen by the arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_new_data;
  logic                      tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_new_data
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_new_data
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning upward from last_i+1, wrapping at NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  output logic [PTR_W-1:0]   pick_o,
  output logic               any_o
);

  int unsigned idx;

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_i) + k) % NUM_REQ;
      if (!any_o && req_i[PTR_W'(idx)]) begin
        pick_o = PTR_W'(idx);
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-level uart_tx among NUM_REQ sources with round-robin,
// per-message grants capped at MAX_BURST bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   pick, hold_idx;
  logic               any_req;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d, hold_data;
  logic               tx_new_data_q, tx_new_data_d;
  logic               last_q, last_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i  (bus.req_valid),
    .last_i (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign hold_idx = PTR_W'(onehot_to_idx(MAX_REQ'(grant_q)));

  // Byte presented by the current holder.
  always_comb begin
    hold_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == hold_idx) hold_data = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_new_data_d = 1'b0;
    last_d        = last_q;
    req_ready_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = NUM_REQ'(1) << pick;
          ptr_d   = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A holder that stops presenting bytes gives up the transmitter.
        if (!bus.req_valid[hold_idx]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (!bus.tx_busy) begin
          req_ready_c[hold_idx] = !rst;
          tx_data_d     = hold_data;
          tx_new_data_d = 1'b1;
          last_d        = bus.req_last[hold_idx];
          cnt_d         = cnt_q + CNT_W'(1);
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (last_q || (cnt_q == CNT_W'(MAX_BURST))) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= PTR_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      tx_data_q     <= '0;
      tx_new_data_q <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_new_data_q <= tx_new_data_d;
      last_q        <= last_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_new_data = tx_new_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// cycle-timeline model of the grant/accept rules, with a simple uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // uart_tx stand-in: busy for busy_len cycles starting the cycle after a strobe.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (bus.tx_new_data) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Model: holder / last holder, bytes in this grant, earliest cycle a byte may be
  // taken (grant cycle, or 3 cycles after the previous byte) and the cycle the
  // grant must read 0 (3 cycles after a closing byte).
  int          holder = -1, last_h = NR - 1, burst = 0, next_acc = 0, rel_at = -1;
  int          cyc = 0, pidx = 0;
  bit          model_on = 1'b0;
  bit          exp_rdy, hv;
  logic [NR-1:0] exp_grant = '0;
  logic        exp_txn = 1'b0;
  logic [7:0]  exp_txd = 8'h00;

  always @(negedge clk) begin
    cyc++;
    hv      = (holder >= 0) ? bus.req_valid[holder] : 1'b0;
    exp_rdy = !rst && holder >= 0 && rel_at < 0 && cyc >= next_acc && hv && !bus.tx_busy;
    if (model_on) begin
      chk("grant", int'(bus.grant), int'(exp_grant));
      chk("req_ready", int'(bus.req_ready), exp_rdy ? (1 << holder) : 0);
      chk("tx_new_data", int'(bus.tx_new_data), int'(exp_txn));
      chk("tx_data", int'(bus.tx_data), int'(exp_txd));
    end
    if (rst) begin
      model_on  = 1'b1;
      holder    = -1;
      last_h    = NR - 1;
      burst     = 0;
      rel_at    = -1;
      exp_grant = '0;
      exp_txn   = 1'b0;
      exp_txd   = 8'h00;
    end else if (model_on) begin
      exp_txn = exp_rdy;
      if (exp_rdy) begin
        exp_txd = bus.req_data[holder*8 +: 8];
        burst++;
        next_acc = cyc + 3;
        if (bus.req_last[holder] || burst == MB) rel_at = cyc + 3;
      end
      if (holder < 0) begin
        for (int k = 1; k <= NR; k++) begin
          pidx = (last_h + k) % NR;
          if (holder < 0 && bus.req_valid[pidx]) begin
            holder    = pidx;
            last_h    = pidx;
            exp_grant = NR'(1) << pidx;
            burst     = 0;
            next_acc  = cyc + 1;
            rel_at    = -1;
          end
        end
      end else if (rel_at == cyc + 1 || (rel_at < 0 && cyc >= next_acc && !hv)) begin
        holder    = -1;
        rel_at    = -1;
        exp_grant = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic [NR*8-1:0] d);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int bl_tab [4] = '{0, 1, 3, 10};

  initial begin
    int got [6];
    int ng, cnt;
    bit done, seen0;
    logic [NR-1:0] pg, nxt;
    logic [NR-1:0] lst;

    drive('0, '0, '0);
    do_reset();

    // Single request with last=1.
    busy_len = 0;
    drive(4'b0001, 4'b0001, 32'h0000_0041);
    samp(); chk("t1_grant_idle", int'(bus.grant), 0);
    tick(); samp();
    chk("t1_grant", int'(bus.grant), 1);
    chk("t1_ready", int'(bus.req_ready), 1);
    tick(); drive('0, '0, '0); samp();
    chk("t1_strobe", int'(bus.tx_new_data), 1);
    chk("t1_data", int'(bus.tx_data), 8'h41);
    tick(); samp();
    chk("t1_hold", int'(bus.grant), 1);
    chk("t1_strobe_off", int'(bus.tx_new_data), 0);
    tick(); samp();
    chk("t1_release", int'(bus.grant), 0);

    // Round-robin over 1011.
    do_reset();
    drive(4'b1011, 4'b1111, 32'hC3B2_A190);
    ng = 0; pg = '0;
    for (int n = 0; n < 300 && ng < 6; n++) begin
      samp();
      if (bus.grant != '0 && bus.grant != pg) begin
        got[ng] = oh2i(bus.grant);
        ng++;
      end
      pg = bus.grant;
    end
    chk("rr_count", ng, 6);
    for (int i = 0; i < ng; i++) chk("rr_order", got[i], rr_exp[i]);
    tick(); drive('0, '0, '0);
    repeat (6) tick();

    // Burst cap on requester 2 with requester 1 waiting.
    do_reset();
    drive(4'b0100, 4'b0000, 32'h0055_0000);
    done = 1'b0; cnt = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      samp();
      if (bus.grant == 4'b0100) begin
        done = 1'b1;
        cnt  = int'(bus.req_ready[2]);
      end
    end
    chk("t3_grant2", int'(done), 1);
    tick(); drive(4'b0110, 4'b0010, 32'h0055_6600);
    done = 1'b0; nxt = '0;
    for (int n = 0; n < 300 && !done; n++) begin
      samp();
      if (bus.req_ready[2]) cnt++;
      if (bus.grant != '0 && bus.grant != 4'b0100) begin
        nxt  = bus.grant;
        done = 1'b1;
      end
    end
    chk("t3_burst_bytes", cnt, MB);
    chk("t3_next_holder", int'(nxt), 4'b0010);
    done = 1'b0; seen0 = 1'b0; nxt = '0;
    for (int n = 0; n < 100 && !done; n++) begin
      samp();
      if (bus.grant == '0) seen0 = 1'b1;
      else if (seen0) begin
        nxt  = bus.grant;
        done = 1'b1;
      end
    end
    chk("t3_back_to_2", int'(nxt), 4'b0100);
    tick(); drive('0, '0, '0);
    repeat (20) tick();

    // Holder 1 stalls after two bytes; requester 3 takes over.
    do_reset();
    drive(4'b1010, 4'b0000, 32'h7700_1100);
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 2; n++) begin
      samp();
      if (bus.req_ready[1]) cnt++;
    end
    tick(); drive(4'b1000, 4'b0000, 32'h7700_1100);
    done = 1'b0; nxt = '0;
    for (int n = 0; n < 50 && !done; n++) begin
      samp();
      if (bus.req_ready[1]) cnt++;
      if (bus.grant != '0 && bus.grant != 4'b0010) begin
        nxt  = bus.grant;
        done = 1'b1;
      end
    end
    chk("t5_stall_bytes", cnt, 2);
    chk("t5_next_holder", int'(nxt), 4'b1000);
    tick(); drive('0, '0, '0);
    repeat (20) tick();

    // Reset while a strobe is on the wire.
    do_reset();
    drive(4'b0001, 4'b0000, 32'h0000_00A5);
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      samp();
      if (bus.req_ready[0]) done = 1'b1;
    end
    chk("t6_accept", int'(done), 1);
    tick(); rst = 1'b1; samp();
    chk("t6_issue_strobe", int'(bus.tx_new_data), 1);
    tick(); rst = 1'b0; drive(4'b1100, 4'b1100, 32'h1234_0000); samp();
    chk("t6_grant_rst", int'(bus.grant), 0);
    chk("t6_strobe_rst", int'(bus.tx_new_data), 0);
    chk("t6_data_rst", int'(bus.tx_data), 0);
    tick(); samp();
    chk("t6_first_grant", int'(bus.grant), 4'b0100);
    tick(); drive('0, '0, '0);
    repeat (20) tick();

    // Randomized traffic under several busy lengths; the model checks every cycle.
    for (int seg = 0; seg < 4; seg++) begin
      busy_len = bl_tab[seg];
      repeat (600) begin
        tick();
        for (int i = 0; i < NR; i++) lst[i] = ($urandom_range(2) == 0);
        if (seg % 2 == 1) drive(NR'($urandom & $urandom), lst, $urandom);
        else drive(NR'($urandom | $urandom), lst, $urandom);
      end
    end
    tick(); drive('0, '0, '0);
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
